// File: rtl/mem_pkg.sv
// Shared types for the memory responder.
// Default geometry, FSM states and request kind bundle.
package mem_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 5;

  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL
  } state_t;

  typedef struct packed {
    logic wb;
    logic fill;
  } req_kind_t;

endpackage

// File: rtl/mem_array_sp.sv
// Single-port 2^ADDR_W x DATA_W array, sync write / sync read.
// Ports: clock, reset (read reg only), we, re, addr, wdata, rdata.
module mem_array_sp
  import mem_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef logic [DEPTH-1:0][DATA_W-1:0] mem_t;

  // Power-up pattern: word i holds i mod 2^DATA_W.
  function automatic mem_t init_mem();
    mem_t m;
    for (int i = 0; i < DEPTH; i++) begin
      m[i] = DATA_W'(i);
    end
    return m;
  endfunction

  mem_t mem = init_mem();

  // Contents survive reset; only the read register clears.
  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: write-back then fill, LATENCY cycles each.
// Ports: clock, reset, req_* handshake, wb/fill address+data, pulses.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int DATA_W  = DATA_W_DEF,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wb,
  input  logic              req_fill,
  input  logic [ADDR_W-1:0] wb_address,
  input  logic [DATA_W-1:0] C_Block_M,
  input  logic [ADDR_W-1:0] fill_address,
  output logic [DATA_W-1:0] M_Block_C,
  output logic              fill_valid,
  output logic              wb_done
);

  generate
    if (LATENCY < 1) begin : g_bad_latency
      $error("mem_responder: LATENCY must be >= 1");
    end
  endgenerate

  localparam int CW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] LAST = CW'(LATENCY - 1);

  state_t            state;
  state_t            nxt;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  req_kind_t         req_kind;
  logic              fill_pend;
  logic [ADDR_W-1:0] wb_addr_q;
  logic [DATA_W-1:0] wb_data_q;
  logic [ADDR_W-1:0] fill_addr_q;
  logic              accept;
  logic              last;
  logic              wb_commit;
  logic              fill_commit;
  logic              arr_we;
  logic              arr_re;
  logic [ADDR_W-1:0] arr_addr;

  assign req_kind  = '{wb: req_wb, fill: req_fill};
  assign req_ready = (state == IDLE) & ~reset;
  assign accept    = req_valid & req_ready;

  // State register
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Request capture; later input changes are ignored.
  always_ff @(posedge clock) begin
    if (accept) begin
      fill_pend   <= req_kind.fill;
      wb_addr_q   <= wb_address;
      wb_data_q   <= C_Block_M;
      fill_addr_q <= fill_address;
    end
  end

  // Next-state
  always_comb begin
    nxt     = state;
    cnt_nxt = cnt;
    unique case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (accept) begin
          if (req_kind.wb) begin
            nxt = WB;
          end else if (req_kind.fill) begin
            nxt = FILL;
          end
        end
      end
      WB: begin
        if (last) begin
          nxt     = fill_pend ? FILL : IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      FILL: begin
        if (last) begin
          nxt     = IDLE;
          cnt_nxt = '0;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        nxt     = IDLE;
        cnt_nxt = '0;
      end
    endcase
  end

  // Outputs; reset gates commits so an in-flight write is dropped.
  always_comb begin
    last        = (cnt == LAST);
    wb_commit   = (state == WB) & last;
    fill_commit = (state == FILL) & last;
    arr_we      = wb_commit & ~reset;
    arr_re      = fill_commit & ~reset;
    arr_addr    = (state == WB) ? wb_addr_q : fill_addr_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wb_done    <= 1'b0;
      fill_valid <= 1'b0;
    end else begin
      wb_done    <= wb_commit;
      fill_valid <= fill_commit;
    end
  end

  mem_array_sp #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_array (
    .clock(clock),
    .reset(reset),
    .we   (arr_we),
    .re   (arr_re),
    .addr (arr_addr),
    .wdata(wb_data_q),
    .rdata(M_Block_C)
  );

endmodule
